// File: rtl/proc_ctrl_pkg.sv
// rtl/proc_ctrl_pkg.sv - state, opcode and ALU select definitions for proc_controller
package proc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h5;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational field extraction from the 16-bit instruction word
module instr_decode (
  input  logic [15:0] ir,
  output logic [3:0]  opcode,
  output logic [3:0]  ra,
  output logic [3:0]  rb,
  output logic [3:0]  rc,
  output logic [7:0]  daddr
);

  assign opcode = ir[15:12];
  assign ra     = ir[11:8];
  assign rb     = ir[7:4];
  assign rc     = ir[3:0];
  assign daddr  = ir[11:4];

endmodule

// File: rtl/proc_controller.sv
// rtl/proc_controller.sv - Moore control FSM for a simple load/store datapath
// Optional feature macro: CTRL_ILLEGAL_HALT_EN (undefined opcodes halt and raise Err).
module proc_controller (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [15:0] IR,
  output logic        PC_clr,
  output logic        PC_up,
  output logic        IR_ld,
  output logic [7:0]  D_addr,
  output logic        D_wr,
  output logic        RF_s,
  output logic        RF_W_en,
  output logic [3:0]  RF_W_addr,
  output logic [3:0]  RF_Ra_addr,
  output logic [3:0]  RF_Rb_addr,
  output logic [2:0]  ALU_s,
  output logic        Halted,
  output logic        Err,
  output logic [3:0]  State
);
  import proc_ctrl_pkg::*;

`ifdef CTRL_ILLEGAL_HALT_EN
  localparam state_t ILLEGAL_NEXT = S_HALT;
`else
  localparam state_t ILLEGAL_NEXT = S_NOOP;
`endif

  state_t      state, next;
  logic        armed;
  logic [3:0]  opcode, ra, rb, rc;
  logic [7:0]  daddr;
  logic [3:0]  ra_q, rb_q, rc_q;
  logic [7:0]  daddr_q;

  instr_decode u_decode (
    .ir     (IR),
    .opcode (opcode),
    .ra     (ra),
    .rb     (rb),
    .rc     (rc),
    .daddr  (daddr)
  );

  // armed keeps INIT silent while reset is held, so PC_clr pulses only after release.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= S_INIT;
      armed   <= 1'b0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      daddr_q <= '0;
    end else begin
      state <= next;
      armed <= 1'b1;
      if (state == S_DECODE) begin
        ra_q    <= ra;
        rb_q    <= rb;
        rc_q    <= rc;
        daddr_q <= daddr;
      end
    end
  end

`ifdef CTRL_ILLEGAL_HALT_EN
  logic err_q;
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      err_q <= 1'b0;
    else if (state == S_DECODE && opcode > OP_HALT)
      err_q <= 1'b1;
  end
  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

  always_comb begin
    next = state;
    case (state)
      S_INIT:   if (armed) next = S_FETCH;
      S_FETCH:  next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_NOOP:  next = S_NOOP;
          OP_STORE: next = S_STORE;
          OP_LOAD:  next = S_LOAD_A;
          OP_ADD:   next = S_ADD;
          OP_SUB:   next = S_SUB;
          OP_HALT:  next = S_HALT;
          default:  next = ILLEGAL_NEXT;
        endcase
      end
      S_LOAD_A: next = S_LOAD_B;
      S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB: next = S_FETCH;
      S_HALT:   next = S_HALT;
      default:  next = S_INIT;
    endcase
  end

  always_comb begin
    PC_clr     = 1'b0;
    PC_up      = 1'b0;
    IR_ld      = 1'b0;
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_en    = 1'b0;
    RF_W_addr  = '0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    ALU_s      = ALU_PASS;
    Halted     = 1'b0;
    case (state)
      S_INIT:  PC_clr = armed;
      S_FETCH: begin
        IR_ld = 1'b1;
        PC_up = 1'b1;
      end
      S_LOAD_A: begin
        D_addr = daddr_q;
        RF_s   = 1'b1;
      end
      S_LOAD_B: begin
        D_addr    = daddr_q;
        RF_s      = 1'b1;
        RF_W_en   = 1'b1;
        RF_W_addr = rc_q;
      end
      S_STORE: begin
        D_addr     = daddr_q;
        RF_Ra_addr = ra_q;
        D_wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = ra_q;
        RF_Rb_addr = rb_q;
        RF_W_addr  = rc_q;
        RF_W_en    = 1'b1;
        ALU_s      = (state == S_ADD) ? ALU_ADD : ALU_SUB;
      end
      S_HALT:  Halted = 1'b1;
      default: ;
    endcase
  end

  assign State = state;

endmodule

// File: tb/tb_proc_controller.sv
// tb/tb_proc_controller.sv - self-checking bench for proc_controller (honours CTRL_ILLEGAL_HALT_EN)
module tb_proc_controller;

  localparam logic [3:0] T_INIT = 4'd0, T_FETCH = 4'd1, T_DECODE = 4'd2, T_NOOP = 4'd3,
                         T_LOAD_A = 4'd4, T_LOAD_B = 4'd5, T_STORE = 4'd6, T_ADD = 4'd7,
                         T_SUB = 4'd8, T_HALT = 4'd9;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [15:0] IR = 16'h0000;
  logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en, Halted, Err;
  logic [7:0]  D_addr;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, State;
  logic [2:0]  ALU_s;

  proc_controller dut (
    .Clk(Clk), .Reset_n(Reset_n), .IR(IR),
    .PC_clr(PC_clr), .PC_up(PC_up), .IR_ld(IR_ld),
    .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s), .RF_W_en(RF_W_en),
    .RF_W_addr(RF_W_addr), .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr),
    .ALU_s(ALU_s), .Halted(Halted), .Err(Err), .State(State)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_clr, pc_up, ir_ld;
    logic [7:0] d_addr;
    logic       d_wr, rf_s, w_en;
    logic [3:0] w_addr, ra, rb;
    logic [2:0] alu;
    logic       halted, err;
  } rec_t;

  rec_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   model_err = 1'b0;

  function automatic rec_t base(input logic [3:0] st);
    rec_t r;
    r = '0;
    r.state = st;
    r.err = model_err;
    return r;
  endfunction

  function automatic rec_t actual();
    rec_t r;
    r.state = State; r.pc_clr = PC_clr; r.pc_up = PC_up; r.ir_ld = IR_ld;
    r.d_addr = D_addr; r.d_wr = D_wr; r.rf_s = RF_s; r.w_en = RF_W_en;
    r.w_addr = RF_W_addr; r.ra = RF_Ra_addr; r.rb = RF_Rb_addr; r.alu = ALU_s;
    r.halted = Halted; r.err = Err;
    return r;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", q.size());
      q.delete();
    end
  endtask

  // Expected per-cycle outputs of one instruction, starting with its FETCH cycle.
  task automatic issue(input logic [15:0] ir);
    rec_t r;
    IR = ir;
    r = base(T_FETCH); r.pc_up = 1'b1; r.ir_ld = 1'b1; q.push_back(r);
    q.push_back(base(T_DECODE));
    case (ir[15:12])
      4'h0: q.push_back(base(T_NOOP));
      4'h1: begin
        r = base(T_STORE); r.d_addr = ir[11:4]; r.ra = ir[11:8]; r.d_wr = 1'b1; q.push_back(r);
      end
      4'h2: begin
        r = base(T_LOAD_A); r.d_addr = ir[11:4]; r.rf_s = 1'b1; q.push_back(r);
        r.state = T_LOAD_B; r.w_en = 1'b1; r.w_addr = ir[3:0]; q.push_back(r);
      end
      4'h3, 4'h4: begin
        r = base(ir[15:12] == 4'h3 ? T_ADD : T_SUB);
        r.ra = ir[11:8]; r.rb = ir[7:4]; r.w_addr = ir[3:0]; r.w_en = 1'b1;
        r.alu = (ir[15:12] == 4'h3) ? 3'b001 : 3'b010;
        q.push_back(r);
      end
      4'h5: begin
        r = base(T_HALT); r.halted = 1'b1; q.push_back(r);
      end
      default: begin
`ifdef CTRL_ILLEGAL_HALT_EN
        model_err = 1'b1;
        r = base(T_HALT); r.halted = 1'b1; q.push_back(r);
`else
        q.push_back(base(T_NOOP));
`endif
      end
    endcase
  endtask

  task automatic release_reset();
    rec_t r;
    @(negedge Clk);
    #1;
    Reset_n = 1'b1;
    model_err = 1'b0;
    r = base(T_INIT); r.pc_clr = 1'b1; q.push_back(r);
  endtask

  task automatic push_halts(input int n);
    rec_t r;
    r = base(T_HALT); r.halted = 1'b1;
    repeat (n) q.push_back(r);
  endtask

  initial begin
    fork
      forever begin
        rec_t e, a;
        @(negedge Clk);
        if (q.size() != 0) begin
          e = q.pop_front();
          a = actual();
          checks++;
          if (a !== e) begin
            failures++;
            $display("FAIL cycle_model t=%0t actual=%h required=%h", $time, a, e);
          end
        end
      end
    join_none

    repeat (2) @(negedge Clk);
    chk("reset_outputs_zero", {PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_en, RF_W_addr,
        RF_Ra_addr, RF_Rb_addr, ALU_s, Halted, Err, State}, 64'd0);

    release_reset();
    issue(16'h0000);
    tick();
    chk("init_pc_clr", {PC_clr, PC_up, State}, {1'b1, 1'b0, 4'd0});
    tick();
    chk("fetch_after_init", {PC_clr, IR_ld, PC_up, State}, {1'b0, 1'b1, 1'b1, 4'd1});
    drain();

    issue(16'h3123);
    tick(); tick();
    chk("add_fields", {RF_Ra_addr, RF_Rb_addr, RF_W_addr, RF_W_en, RF_s, ALU_s},
        {4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 3'b001});
    drain();

    issue(16'h4456);
    tick(); tick();
    chk("sub_fields", {ALU_s, RF_Ra_addr, RF_Rb_addr, RF_W_addr}, {3'b010, 4'd4, 4'd5, 4'd6});
    drain();

    issue(16'h2A53);
    tick(); tick();
    chk("load_a", {D_addr, RF_s, RF_W_en, RF_W_addr}, {8'hA5, 1'b1, 1'b0, 4'd0});
    tick();
    chk("load_b", {D_addr, RF_s, RF_W_en, RF_W_addr}, {8'hA5, 1'b1, 1'b1, 4'd3});
    drain();

    issue(16'h0ABC);
    drain();

    issue(16'hF000);
    tick(); tick();
`ifdef CTRL_ILLEGAL_HALT_EN
    chk("illegal_halts", {Halted, Err, State}, {1'b1, 1'b1, 4'd9});
    push_halts(4);
`else
    chk("illegal_noop", {Halted, Err, State}, {1'b0, 1'b0, 4'd3});
`endif
    drain();

    Reset_n = 1'b0;
    tick();
    chk("reset_clears_err", {Err, Halted, State}, 64'd0);
    release_reset();
    issue(16'h2A53);
    void'(q.pop_back());
    void'(q.pop_back());
    tick(); tick(); tick(); tick();
    chk("mid_load_a", {D_addr, RF_s, State}, {8'hA5, 1'b1, 4'd4});
    #2 Reset_n = 1'b0;
    #1;
    chk("async_reset_zero", {PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_en, RF_W_addr,
        RF_Ra_addr, RF_Rb_addr, ALU_s, Halted, Err, State}, 64'd0);
    repeat (2) begin
      @(negedge Clk);
      chk("reset_hold_no_write", {RF_W_en, D_wr, PC_clr, State}, 64'd0);
    end

    release_reset();
    issue(16'h1F00);
    tick(); tick(); tick(); tick();
    chk("store", {D_addr, RF_Ra_addr, D_wr, RF_W_en}, {8'hF0, 4'hF, 1'b1, 1'b0});
    drain();

    issue(16'h5000);
    push_halts(20);
    tick(); tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      IR = (i % 2 == 0) ? 16'h3123 : 16'h2A53;
    end
    chk("halt_sticky", {Halted, State, D_wr, RF_W_en}, {1'b1, 4'd9, 1'b0, 1'b0});
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
